// File: rtl/xyolo_seq.sv
// xyolo_seq: run sequencer for the MAC datapath (operand strobes, accumulator/result/maxpool loads).
// Optional maxpool grouping is compiled in by defining XYOLO_SEQ_MAXPOOL_EN.
module xyolo_seq #(
  parameter int N_MACS   = 1,
  parameter int N_MACS_W = $clog2(N_MACS) + ($clog2(N_MACS) == 0),
  parameter int KER_W    = 12,
  parameter int LAT      = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KER_W-1:0]    cfg_ker_len,
  input  logic [15:0]         cfg_nwin,
  input  logic                cfg_maxpool,
  input  logic                cfg_bypass,
  output logic                busy,
  output logic                done,
  output logic                op_en,
  output logic                ld_acc,
  output logic                ld_res,
  output logic                ld_mp,
  output logic [N_MACS_W-1:0] ld_nmac,
  output logic                out_valid,
  output logic                dp_maxpool,
  output logic                dp_bypass
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  // All delay-line taps except the output tap.
  localparam logic [LAT-1:0] DL_OTHERS = {LAT{1'b1}} >> 1;

  state_t              state_q, state_d;
  logic [KER_W-1:0]    ker_q, elem_q, elem_d;
  logic [15:0]         nwin_q, win_q, win_d;
  logic [N_MACS_W-1:0] nmac_q, nmac_d;
  logic [LAT-1:0]      dl_q, dl_d;
  logic                byp_mode_q;
  logic                byp_q, byp_d;
  logic                ov_q, ov_d;
  logic                mark;
  logic                launch;

  assign launch = (state_q == IDLE) && start;

  always_comb begin
    state_d = state_q;
    elem_d  = elem_q;
    win_d   = win_q;
    nmac_d  = nmac_q;
    mark    = 1'b0;
    byp_d   = 1'b0;
    op_en   = 1'b0;
    ld_acc  = 1'b0;
    ld_nmac = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          elem_d  = '0;
          win_d   = '0;
          nmac_d  = '0;
          state_d = (cfg_nwin == 16'd0) ? DONE : FEED;
        end
      end
      FEED: begin
        if (byp_mode_q) begin
          // One pixel per cycle; operands are only fetched when lane 0 is loaded.
          ld_nmac = nmac_q;
          op_en   = (nmac_q == '0);
          byp_d   = 1'b1;
          nmac_d  = (nmac_q == N_MACS_W'(N_MACS - 1)) ? '0 : nmac_q + N_MACS_W'(1);
          win_d   = win_q + 16'd1;
          if (win_q == nwin_q - 16'd1) state_d = DRAIN;
        end else begin
          op_en  = 1'b1;
          ld_acc = (elem_q == '0);
          if (elem_q == ker_q - KER_W'(1)) begin
            mark   = 1'b1;
            elem_d = '0;
            win_d  = win_q + 16'd1;
            if (win_q == nwin_q - 16'd1) state_d = DRAIN;
          end else begin
            elem_d = elem_q + KER_W'(1);
          end
        end
      end
      DRAIN:   if ((dl_q == '0) && !byp_q) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign dl_d      = (dl_q << 1) | LAT'(mark);
  assign ld_res    = dl_q[LAT-1] | byp_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign out_valid = ov_q;
  assign dp_bypass = byp_mode_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ker_q      <= '0;
      nwin_q     <= '0;
      byp_mode_q <= 1'b0;
      elem_q     <= '0;
      win_q      <= '0;
      nmac_q     <= '0;
      dl_q       <= '0;
      byp_q      <= 1'b0;
      ov_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      win_q   <= win_d;
      nmac_q  <= nmac_d;
      dl_q    <= dl_d;
      byp_q   <= byp_d;
      ov_q    <= ov_d;
      if (launch) begin
        ker_q      <= (cfg_ker_len == '0) ? KER_W'(1) : cfg_ker_len;
        nwin_q     <= cfg_nwin;
        byp_mode_q <= cfg_bypass;
      end
    end
  end

`ifdef XYOLO_SEQ_MAXPOOL_EN
  logic       mp_q;
  logic [1:0] grp_q, grp_d;
  logic       last_res;

  // The final result of a run is the one leaving the pipe in DRAIN with nothing behind it.
  assign last_res = ld_res && (state_q == DRAIN) && ((dl_q & DL_OTHERS) == '0);
  assign grp_d    = launch ? 2'd0 : (ld_res ? grp_q + 2'd1 : grp_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mp_q  <= 1'b0;
      grp_q <= 2'd0;
    end else begin
      grp_q <= grp_d;
      if (launch) mp_q <= cfg_maxpool;
    end
  end

  assign ld_mp      = mp_q && ld_res && (grp_q != 2'd0);
  assign ov_d       = ld_res && (!mp_q || (grp_q == 2'd3) || last_res);
  assign dp_maxpool = mp_q;
`else
  logic unused_cfg_maxpool;
  logic unused_dl_others;
  assign unused_cfg_maxpool = cfg_maxpool;
  assign unused_dl_others   = |DL_OTHERS;
  assign ld_mp      = 1'b0;
  assign ov_d       = ld_res;
  assign dp_maxpool = 1'b0;
`endif

endmodule

// File: tb/tb_xyolo_seq.sv
// Bench for xyolo_seq: per-cycle comparison against a trace model derived from the run configuration.
module tb_xyolo_seq;
  localparam int NM  = 4;
  localparam int LAT = 5;
  localparam int KW  = 12;
  localparam int H   = 96;

  logic          clk;
  logic          rst;
  logic          start;
  logic [KW-1:0] cfg_ker_len;
  logic [15:0]   cfg_nwin;
  logic          cfg_maxpool;
  logic          cfg_bypass;
  logic          busy, done, op_en, ld_acc, ld_res, ld_mp, out_valid, dp_maxpool, dp_bypass;
  logic [1:0]    ld_nmac;

  xyolo_seq #(.N_MACS(NM), .N_MACS_W(2), .KER_W(KW), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_ker_len(cfg_ker_len), .cfg_nwin(cfg_nwin),
    .cfg_maxpool(cfg_maxpool), .cfg_bypass(cfg_bypass), .busy(busy), .done(done),
    .op_en(op_en), .ld_acc(ld_acc), .ld_res(ld_res), .ld_mp(ld_mp), .ld_nmac(ld_nmac),
    .out_valid(out_valid), .dp_maxpool(dp_maxpool), .dp_bypass(dp_bypass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Expected per-cycle trace, cycle 0 = the cycle start is presented.
  int e_op[H], e_acc[H], e_res[H], e_mp[H], e_ov[H], e_nm[H];
  int e_done;
  bit cur_mp, cur_byp;

  function automatic bit mp_eff(input bit mp);
`ifdef XYOLO_SEQ_MAXPOOL_EN
    return mp;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, c, obs, exp);
    end
  endtask

  task automatic build(input int k, input int n, input bit mp, input bit byp);
    int kk, j, last;
    kk = (k == 0) ? 1 : k;
    for (int c = 0; c < H; c++) begin
      e_op[c] = 0; e_acc[c] = 0; e_res[c] = 0; e_mp[c] = 0; e_ov[c] = 0; e_nm[c] = 0;
    end
    cur_mp  = mp;
    cur_byp = byp;
    if (n == 0) begin
      e_done = 1;
    end else begin
      if (!byp) begin
        for (int i = 0; i < kk * n; i++) begin
          e_op[1 + i]  = 1;
          e_acc[1 + i] = (i % kk == 0);
          if (i % kk == kk - 1) e_res[1 + i + LAT] = 1;
        end
      end else begin
        for (int i = 0; i < n; i++) begin
          e_nm[1 + i]  = i % NM;
          e_op[1 + i]  = (i % NM == 0);
          e_res[2 + i] = 1;
        end
      end
      j = 0;
      last = 0;
      for (int c = 0; c < H - 1; c++) begin
        if (e_res[c] != 0) begin
          e_mp[c] = (mp && (j % 4 != 0));
          if (!mp || (j % 4 == 3) || (j == n - 1)) begin
            e_ov[c + 1] = 1;
            last = c + 1;
          end
          j++;
        end
      end
      e_done = last + 1;
    end
  endtask

  task automatic cycle_check(input int c);
    chk("busy",      c, busy,      (c >= 1 && c <= e_done));
    chk("done",      c, done,      (c == e_done));
    chk("op_en",     c, op_en,     e_op[c]);
    chk("ld_acc",    c, ld_acc,    e_acc[c]);
    chk("ld_res",    c, ld_res,    e_res[c]);
    chk("ld_mp",     c, ld_mp,     e_mp[c]);
    chk("ld_nmac",   c, ld_nmac,   e_nm[c]);
    chk("out_valid", c, out_valid, e_ov[c]);
    if (c >= 1 && c <= e_done) begin
      chk("dp_maxpool", c, dp_maxpool, cur_mp);
      chk("dp_bypass",  c, dp_bypass,  cur_byp);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"},  0, busy,      0);
    chk({tag, "_done"},  0, done,      0);
    chk({tag, "_op"},    0, op_en,     0);
    chk({tag, "_acc"},   0, ld_acc,    0);
    chk({tag, "_res"},   0, ld_res,    0);
    chk({tag, "_mp"},    0, ld_mp,     0);
    chk({tag, "_nmac"},  0, ld_nmac,   0);
    chk({tag, "_ov"},    0, out_valid, 0);
    chk({tag, "_dpmp"},  0, dp_maxpool, 0);
    chk({tag, "_dpbyp"}, 0, dp_bypass, 0);
  endtask

  task automatic present(input int k, input int n, input bit mp, input bit byp);
    @(negedge clk);
    start       = 1'b1;
    cfg_ker_len = KW'(k);
    cfg_nwin    = 16'(n);
    cfg_maxpool = mp;
    cfg_bypass  = byp;
  endtask

  // Starts a run and checks every cycle until one past done; start is kept toggling with
  // junk configuration while busy, which the sequencer must ignore.
  task automatic run(input int k, input int n, input bit mp, input bit byp);
    build(k, n, mp_eff(mp), byp);
    present(k, n, mp, byp);
    for (int c = 1; c <= e_done + 1; c++) begin
      @(negedge clk);
      cycle_check(c);
      if (c <= e_done) begin
        start       = 1'($urandom_range(0, 1));
        cfg_ker_len = KW'($urandom_range(0, 7));
        cfg_nwin    = 16'($urandom_range(0, 9));
        cfg_maxpool = 1'($urandom_range(0, 1));
        cfg_bypass  = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cfg_ker_len = '0; cfg_nwin = '0; cfg_maxpool = 1'b0; cfg_bypass = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    run(3, 2, 1'b0, 1'b0);
    run(1, 4, 1'b1, 1'b0);
    run(2, 6, 1'b0, 1'b1);
    run(3, 0, 1'b0, 1'b0);
    run(0, 3, 1'b0, 1'b0);
    run(2, 5, 1'b1, 1'b0);
    run(1, 9, 1'b1, 1'b1);

    // Reset in the middle of a run, then the same run again from scratch.
    build(3, 2, 1'b0, 1'b0);
    present(3, 2, 1'b0, 1'b0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      cycle_check(c);
      start = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("midrun_rst");
    @(negedge clk);
    check_zero("held_rst");
    rst = 1'b0;
    @(negedge clk);
    check_zero("post_rst");
    run(3, 2, 1'b0, 1'b0);

    for (int r = 0; r < 24; r++) begin
      run(int'($urandom_range(0, 5)), int'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
